// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand select, ALU, data-memory
// handshake with a bounded wait, and the registered *_M outputs for writeback.
module ex_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [1:0]  WDSRC_E,
  input  logic        WEN_E,
  input  logic        MemToReg_E,
  input  logic        DRW_E,
  input  logic        DREQ_E,
  input  logic        ALUSRC1_E,
  input  logic [2:0]  ALUSRC2_E,
  input  logic [3:0]  ALUOP_E,
  input  logic [4:0]  shamt_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] DA_E,
  input  logic [31:0] PCADD4_E,
  input  logic [31:0] Jext_E,
  input  logic [31:0] zeroExt_E,
  input  logic [31:0] Iext_E,
  output logic        DMEM_REQ,
  output logic        DMEM_RW,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALL,
  output logic        MEM_ERR,
  output logic [1:0]  WDSRC_M,
  output logic        WEN_M,
  output logic        MemToReg_M,
  output logic [31:0] DA_M,
  output logic [31:0] PCADD4_M,
  output logic [31:0] ALURES_M,
  output logic [31:0] MEMDATA_M
);
  localparam int CW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   alu_a, alu_b, alu_res;
  logic [63:0]   ror_w;
  logic [4:0]    sh;
  logic          timeout_now, rd_done;

  assign alu_a = ALUSRC1_E ? PCADD4_E : RD1_E;
  assign sh    = alu_b[4:0];

  always_comb begin
    alu_b = '0;
    case (ALUSRC2_E)
      3'd0:    alu_b = RD2_E;
      3'd1:    alu_b = Iext_E;
      3'd2:    alu_b = zeroExt_E;
      3'd3:    alu_b = Jext_E;
      3'd4:    alu_b = {27'b0, shamt_E};
      default: alu_b = '0;
    endcase
  end

  // Rotate via a doubled word so a zero shift needs no special case.
  always_comb begin
    ror_w   = {alu_a, alu_a} >> sh;
    alu_res = alu_b;
    case (ALUOP_E)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a & alu_b;
      4'd3:    alu_res = alu_a | alu_b;
      4'd4:    alu_res = alu_a ^ alu_b;
      4'd5:    alu_res = ~alu_b;
      4'd6:    alu_res = -alu_b;
      4'd7:    alu_res = alu_a << sh;
      4'd8:    alu_res = alu_a >> sh;
      4'd9:    alu_res = $unsigned($signed(alu_a) >>> sh);
      4'd10:   alu_res = ror_w[31:0];
      default: alu_res = alu_b;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_now = 1'b0;
    case (state)
      IDLE: if (DREQ_E && !DMEM_ACK) begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (DMEM_ACK) state_nxt = IDLE;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          timeout_now = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign DMEM_REQ   = RSTN & (((state == IDLE) & DREQ_E) | (state == WAIT));
  assign DMEM_RW    = DRW_E;
  assign DMEM_ADDR  = alu_res;
  assign DMEM_WDATA = RD2_E;
  // ACK beats a coincident timeout because timeout_now already requires ~ACK.
  assign STALL      = DMEM_REQ & ~DMEM_ACK & ~timeout_now;
  assign rd_done    = DMEM_REQ & DMEM_ACK & ~DRW_E;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      WDSRC_M    <= '0;
      WEN_M      <= 1'b0;
      MemToReg_M <= 1'b0;
      DA_M       <= '0;
      PCADD4_M   <= '0;
      ALURES_M   <= '0;
      MEMDATA_M  <= '0;
      MEM_ERR    <= 1'b0;
    end else if (STALL) begin
      WEN_M      <= 1'b0;
      MemToReg_M <= 1'b0;
    end else begin
      WDSRC_M    <= WDSRC_E;
      WEN_M      <= WEN_E;
      MemToReg_M <= MemToReg_E;
      DA_M       <= DA_E;
      PCADD4_M   <= PCADD4_E;
      ALURES_M   <= alu_res;
      if (timeout_now) begin
        MEMDATA_M <= '0;
        MEM_ERR   <= 1'b1;
      end else if (rd_done) MEMDATA_M <= DMEM_RDATA;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each issued instruction pushes its expected
// *_M image, which is popped and compared once the stage retires it.
module tb_ex_mem_stage;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [1:0]  WDSRC_E;
  logic        WEN_E, MemToReg_E, DRW_E, DREQ_E, ALUSRC1_E;
  logic [2:0]  ALUSRC2_E;
  logic [3:0]  ALUOP_E;
  logic [4:0]  shamt_E;
  logic [31:0] RD1_E, RD2_E, DA_E, PCADD4_E, Jext_E, zeroExt_E, Iext_E;
  logic        DMEM_REQ, DMEM_RW, DMEM_ACK, STALL, MEM_ERR;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [1:0]  WDSRC_M;
  logic        WEN_M, MemToReg_M;
  logic [31:0] DA_M, PCADD4_M, ALURES_M, MEMDATA_M;

  always #5 CLK = ~CLK;

  ex_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTN(RSTN), .WDSRC_E(WDSRC_E), .WEN_E(WEN_E), .MemToReg_E(MemToReg_E),
    .DRW_E(DRW_E), .DREQ_E(DREQ_E), .ALUSRC1_E(ALUSRC1_E), .ALUSRC2_E(ALUSRC2_E),
    .ALUOP_E(ALUOP_E), .shamt_E(shamt_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .DA_E(DA_E),
    .PCADD4_E(PCADD4_E), .Jext_E(Jext_E), .zeroExt_E(zeroExt_E), .Iext_E(Iext_E),
    .DMEM_REQ(DMEM_REQ), .DMEM_RW(DMEM_RW), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .STALL(STALL), .MEM_ERR(MEM_ERR),
    .WDSRC_M(WDSRC_M), .WEN_M(WEN_M), .MemToReg_M(MemToReg_M), .DA_M(DA_M),
    .PCADD4_M(PCADD4_M), .ALURES_M(ALURES_M), .MEMDATA_M(MEMDATA_M)
  );

  typedef struct {
    logic [1:0]  wdsrc;
    logic        m2r, err;
    logic [31:0] da, alures, memdata;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_memdata = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ack_dly: cycle (0 = request cycle) on which ACK is raised; -1 = never.
  task automatic issue(input string tag, input logic [3:0] op, input logic src1,
                       input logic [2:0] src2, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [4:0] sh, input logic dreq, input logic drw,
                       input int ack_dly, input logic [31:0] rdata,
                       input logic [31:0] exp_alu, input int exp_stalls);
    exp_t e, p;
    int   stalls;
    logic st, done;
    ALUOP_E = op; ALUSRC1_E = src1; ALUSRC2_E = src2; RD1_E = rd1; RD2_E = rd2;
    shamt_E = sh; DREQ_E = dreq; DRW_E = drw; WEN_E = 1'b1; MemToReg_E = dreq & ~drw;
    WDSRC_E = 2'($urandom_range(3)); DA_E = $urandom; DMEM_RDATA = rdata;
    if (dreq && (ack_dly < 0 || ack_dly > TIMEOUT)) begin
      exp_memdata = '0;
      exp_err     = 1'b1;
    end else if (dreq && !drw) exp_memdata = rdata;
    e.wdsrc = WDSRC_E; e.m2r = MemToReg_E; e.da = DA_E; e.alures = exp_alu;
    e.memdata = exp_memdata; e.err = exp_err; e.stalls = exp_stalls;
    sb.push_back(e);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      DMEM_ACK = (k == ack_dly);
      #1;
      if (k == 0) begin
        chk({tag, ".req"}, 32'(DMEM_REQ), 32'(dreq));
        if (dreq) begin
          chk({tag, ".addr"}, DMEM_ADDR, exp_alu);
          chk({tag, ".rw"}, 32'(DMEM_RW), 32'(drw));
          chk({tag, ".wdata"}, DMEM_WDATA, rd2);
        end
      end
      st = STALL;
      @(posedge CLK); #1;
      if (st) begin
        stalls++;
        chk({tag, ".bubble"}, {30'b0, WEN_M, MemToReg_M}, 32'b0);
      end else done = 1'b1;
      @(negedge CLK);
    end
    DMEM_ACK = 1'b0;
    if (!done) chk({tag, ".retire_bound"}, 32'(done), 32'd1);
    p = sb.pop_front();
    chk({tag, ".stalls"}, 32'(stalls), 32'(p.stalls));
    chk({tag, ".alures"}, ALURES_M, p.alures);
    chk({tag, ".memdata"}, MEMDATA_M, p.memdata);
    chk({tag, ".ctl"}, {27'b0, WDSRC_M, WEN_M, MemToReg_M, MEM_ERR},
        {27'b0, p.wdsrc, 1'b1, p.m2r, p.err});
    chk({tag, ".da"}, DA_M, p.da);
    chk({tag, ".pc4"}, PCADD4_M, 32'h1000);
  endtask

  initial begin
    RSTN = 1'b0; DREQ_E = 1'b1; DRW_E = 1'b0; WEN_E = 1'b1; MemToReg_E = 1'b1;
    WDSRC_E = 2'd3; ALUSRC1_E = 1'b0; ALUSRC2_E = 3'd0; ALUOP_E = 4'd0; shamt_E = '0;
    RD1_E = 32'h11; RD2_E = 32'h22; DA_E = 32'h5; PCADD4_E = 32'h1000; Jext_E = 32'h20;
    zeroExt_E = 32'h55; Iext_E = 32'h0000FF00; DMEM_RDATA = '0; DMEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.req_stall", {30'b0, DMEM_REQ, STALL}, 32'b0);
    chk("rst.ctl", {27'b0, WDSRC_M, WEN_M, MemToReg_M, MEM_ERR}, 32'b0);
    chk("rst.alures", ALURES_M, 32'b0);
    chk("rst.memdata", MEMDATA_M, 32'b0);
    chk("rst.da_pc4", DA_M | PCADD4_M, 32'b0);
    @(negedge CLK);
    RSTN = 1'b1; DREQ_E = 1'b0;

    issue("add",  4'd0,  1'b0, 3'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, -1, '0, 32'd12, 0);
    issue("sub",  4'd1,  1'b0, 3'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, -1, '0, 32'hFFFFFFFE, 0);
    issue("and",  4'd2,  1'b0, 3'd1, 32'h1234F0F0, 32'd0, 5'd0, 1'b0, 1'b0, -1, '0, 32'h0000F000, 0);
    issue("sra",  4'd9,  1'b0, 3'd4, 32'h80000000, 32'd0, 5'd4, 1'b0, 1'b0, -1, '0, 32'hF8000000, 0);
    issue("ror",  4'd10, 1'b0, 3'd4, 32'h80000000, 32'd0, 5'd4, 1'b0, 1'b0, -1, '0, 32'h08000000, 0);
    issue("ror0", 4'd10, 1'b0, 3'd4, 32'h80000001, 32'd0, 5'd0, 1'b0, 1'b0, -1, '0, 32'h80000001, 0);
    issue("sll",  4'd7,  1'b0, 3'd4, 32'd1, 32'd0, 5'd31, 1'b0, 1'b0, -1, '0, 32'h80000000, 0);
    issue("pcj",  4'd0,  1'b1, 3'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, -1, '0, 32'h00001020, 0);
    issue("negb", 4'd6,  1'b0, 3'd0, 32'd9, 32'd1, 5'd0, 1'b0, 1'b0, -1, '0, 32'hFFFFFFFF, 0);
    issue("ld3",  4'd0,  1'b0, 3'd0, 32'h200, 32'd4, 5'd0, 1'b1, 1'b0, 3, 32'hDEADBEEF, 32'h204, 3);
    issue("st0",  4'd0,  1'b0, 3'd5, 32'h100, 32'hCAFE0001, 5'd0, 1'b1, 1'b1, 0, 32'h0, 32'h100, 0);
    issue("stray",4'd3,  1'b0, 3'd2, 32'hA0, 32'd0, 5'd0, 1'b0, 1'b0, 0, 32'h777, 32'hF5, 0);
    issue("ld16", 4'd0,  1'b0, 3'd0, 32'h300, 32'd0, 5'd0, 1'b1, 1'b0, 16, 32'h55AA, 32'h300, 16);
    issue("ldto", 4'd0,  1'b0, 3'd0, 32'h400, 32'd0, 5'd0, 1'b1, 1'b0, -1, 32'h1234, 32'h400, 16);

    // Reset in the middle of an outstanding access.
    DREQ_E = 1'b1; DRW_E = 1'b0; DMEM_ACK = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("midwait.stall", 32'(STALL), 32'd1);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    chk("midwait.req_stall", {30'b0, DMEM_REQ, STALL}, 32'b0);
    chk("midwait.ctl", {27'b0, WDSRC_M, WEN_M, MemToReg_M, MEM_ERR}, 32'b0);
    chk("midwait.data", ALURES_M | MEMDATA_M | DA_M | PCADD4_M, 32'b0);
    @(negedge CLK);
    DREQ_E = 1'b0; RSTN = 1'b1;
    @(posedge CLK); #1;
    chk("midwait.idle", {30'b0, DMEM_REQ, STALL}, 32'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
